// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage RISC pipeline.
// Holds the MEM/WB pipeline register and drives the register-file write port.
// Outputs depend only on the registered fields, so they are stable for a whole
// cycle and nothing passes combinationally from the inputs to the outputs.
module wb_stage #(
    parameter int word_size = 32,
    parameter int reg_size  = 5
) (
    output logic [reg_size-1:0]  WriteReg,
    output logic [word_size-1:0] WriteData,
    output logic                 RegWrite,
    input  logic [word_size-1:0] ReadData,
    input  logic [word_size-1:0] AluResult,
    input  logic [reg_size-1:0]  destination_reg,
    input  logic [1:0]           wb_control_signals,
    input  logic                 clk,
    input  logic                 rst
);

    // MEM/WB pipeline register fields
    logic [word_size-1:0] read_data_r;
    logic [word_size-1:0] alu_result_r;
    logic [reg_size-1:0]  dest_reg_r;
    logic [1:0]           ctrl_r;

    // Combinational views of the registered fields
    logic [word_size-1:0] write_data_s;
    logic                 reg_write_s;

    // Selects the write-back source: MemtoReg = 1 picks the loaded word.
    function automatic logic [word_size-1:0] wb_select(
        input logic                 mem_to_reg,
        input logic [word_size-1:0] mem_word,
        input logic [word_size-1:0] alu_word
    );
        logic [word_size-1:0] result;
        if (mem_to_reg) begin
            result = mem_word;
        end else begin
            result = alu_word;
        end
        return result;
    endfunction

    // Capture the MEM/WB fields every cycle; reset clears them and drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_r  <= '0;
            alu_result_r <= '0;
            dest_reg_r   <= '0;
            ctrl_r       <= 2'b00;
        end else begin
            read_data_r  <= ReadData;
            alu_result_r <= AluResult;
            dest_reg_r   <= destination_reg;
            ctrl_r       <= wb_control_signals;
        end
    end

    // Decode the registered control: source select and write enable with r0 suppression.
    always_comb begin
        write_data_s = '0;
        reg_write_s  = 1'b0;
        write_data_s = wb_select(ctrl_r[0], read_data_r, alu_result_r);
        // r0 is hard-wired to zero, so a write to it is never issued
        if (ctrl_r[1] && (dest_reg_r != '0)) begin
            reg_write_s = 1'b1;
        end else begin
            reg_write_s = 1'b0;
        end
    end

    assign WriteReg  = dest_reg_r;
    assign WriteData = write_data_s;
    assign RegWrite  = reg_write_s;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData;
    logic [31:0] AluResult;
    logic [4:0]  destination_reg;
    logic [1:0]  wb_control_signals;

    int tests;
    int failed;

    typedef struct {
        logic        rst;
        logic [1:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        exp_we;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [12];

    wb_stage #(.word_size(32), .reg_size(5)) dut (
        .WriteReg           (WriteReg),
        .WriteData          (WriteData),
        .RegWrite           (RegWrite),
        .ReadData           (ReadData),
        .AluResult          (AluResult),
        .destination_reg    (destination_reg),
        .wb_control_signals (wb_control_signals),
        .clk                (clk),
        .rst                (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        check({tag, ".RegWrite"},  {31'd0, RegWrite}, {31'd0, we});
        check({tag, ".WriteReg"},  {27'd0, WriteReg}, {27'd0, wr});
        check({tag, ".WriteData"}, WriteData, wd);
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        //            rst   ctrl   ReadData      AluResult     dst     we    wr      wd
        vecs[0]  = '{1'b0, 2'b00, 32'h00000016, 32'h00000014, 5'h02, 1'b0, 5'h02, 32'h00000014};
        vecs[1]  = '{1'b0, 2'b01, 32'h00000016, 32'h00000014, 5'h02, 1'b0, 5'h02, 32'h00000016};
        vecs[2]  = '{1'b0, 2'b10, 32'h00000016, 32'h00000014, 5'h02, 1'b1, 5'h02, 32'h00000014};
        vecs[3]  = '{1'b0, 2'b11, 32'h00000016, 32'h00000014, 5'h02, 1'b1, 5'h02, 32'h00000016};
        vecs[4]  = '{1'b0, 2'b11, 32'h00000016, 32'h00000014, 5'h00, 1'b0, 5'h00, 32'h00000016};
        vecs[5]  = '{1'b0, 2'b10, 32'hAAAA5555, 32'h12345678, 5'h1F, 1'b1, 5'h1F, 32'h12345678};
        vecs[6]  = '{1'b0, 2'b11, 32'hDEADBEEF, 32'h00000000, 5'h10, 1'b1, 5'h10, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h07, 1'b0, 5'h00, 32'h00000000};
        vecs[8]  = '{1'b0, 2'b11, 32'hCAFEF00D, 32'h00000001, 5'h03, 1'b1, 5'h03, 32'hCAFEF00D};
        vecs[9]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 32'h0000FFFF, 5'h1F, 1'b0, 5'h1F, 32'h0000FFFF};
        vecs[10] = '{1'b0, 2'b10, 32'h00000077, 32'h00000005, 5'h00, 1'b0, 5'h00, 32'h00000005};
        vecs[11] = '{1'b0, 2'b01, 32'h00000000, 32'h00000009, 5'h01, 1'b0, 5'h01, 32'h00000000};

        // Reset held for two cycles with busy inputs
        rst                = 1'b1;
        wb_control_signals = 2'b11;
        ReadData           = 32'h13579BDF;
        AluResult          = 32'h2468ACE0;
        destination_reg    = 5'h05;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("reset%0d", i), 1'b0, 5'h00, 32'h00000000);
        end

        // Table: each entry is captured on one edge and checked just after it
        for (int i = 0; i < 12; i++) begin
            rst                = vecs[i].rst;
            wb_control_signals = vecs[i].ctrl;
            ReadData           = vecs[i].rd;
            AluResult          = vecs[i].alu;
            destination_reg    = vecs[i].dst;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_wr, vecs[i].exp_wd);
        end

        // Inputs changing mid-cycle must not reach the outputs before the next edge
        rst                = 1'b0;
        wb_control_signals = 2'b10;
        ReadData           = 32'h11111111;
        AluResult          = 32'h22222222;
        destination_reg    = 5'h0A;
        #2;
        check_all("hold", 1'b0, 5'h01, 32'h00000000);
        @(posedge clk);
        #1;
        check_all("after_hold", 1'b1, 5'h0A, 32'h22222222);

        // Reset wins over capture on the same edge, then the next instruction resumes
        rst                = 1'b1;
        wb_control_signals = 2'b11;
        ReadData           = 32'h55555555;
        destination_reg    = 5'h04;
        @(posedge clk);
        #1;
        check_all("rst_prio", 1'b0, 5'h00, 32'h00000000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("resume", 1'b1, 5'h04, 32'h55555555);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
